// File: rtl/game_input_pkg.sv
// Shared types and default timing constants for the game input controller.
package game_input_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_RATE     = 5000000;

    localparam int NUM_BTN = 2;
    localparam int NUM_SW  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // Counter width for a terminal count of n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_input_if.sv
// Input-side and event-side signals of the game input controller.
interface game_input_if;
    import game_input_pkg::*;

    logic [NUM_BTN-1:0] key_in;
    logic [NUM_BTN-1:0] mcu_btn;
    logic [NUM_SW-1:0]  mcu_sw;
    logic               mcu_str;

    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_repeat;
    logic [NUM_SW-1:0]  sw_level;
    logic               sw_change;
    logic               game_en;

    modport master (
        output key_in, mcu_btn, mcu_sw, mcu_str,
        input  btn_level, btn_press, btn_release, btn_repeat,
               sw_level, sw_change, game_en
    );

    modport slave (
        input  key_in, mcu_btn, mcu_sw, mcu_str,
        output btn_level, btn_press, btn_release, btn_repeat,
               sw_level, sw_change, game_en
    );

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus counting debouncer for one active-low push-button.
module key_debounce
    import game_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_key_n,
    output logic o_level,
    output logic o_raw
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_raw;

    assign w_raw = ~r_sync2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            if (w_raw == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt >= CNT_LAST) begin
                r_level <= w_raw;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_raw   = w_raw;

endmodule

// File: rtl/game_input_ctrl.sv
// Merges debounced keys with MCU buttons, generates press/release/repeat events,
// and registers the MCU switches and game enable.
module game_input_ctrl
    import game_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input logic         CLK,
    input logic         RST,
    game_input_if.slave bus
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCW     = cnt_width(RPT_MAX);
    localparam logic [RCW-1:0] DELAY_LAST = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] RATE_LAST  = RCW'(REPEAT_RATE - 1);

    logic [NUM_BTN-1:0] w_deb;
    logic [NUM_BTN-1:0] w_raw;
    logic [NUM_BTN-1:0] w_merged;
    logic [NUM_BTN-1:0] w_rise;
    logic [NUM_BTN-1:0] w_fall;
    logic [NUM_BTN-1:0] w_fire;
    logic               w_en_nxt;

    logic [NUM_BTN-1:0] r_level;
    logic [NUM_BTN-1:0] r_press;
    logic [NUM_BTN-1:0] r_release;
    logic [NUM_BTN-1:0] r_repeat;
    logic [NUM_BTN-1:0] r_armed;
    logic [1:0]         r_settle;
    logic [NUM_SW-1:0]  r_sw;
    logic [NUM_SW-1:0]  r_sw_d;
    logic               r_sw_change;
    logic               r_game_en;

    rpt_state_t         r_state     [NUM_BTN];
    rpt_state_t         w_state_nxt [NUM_BTN];
    logic [RCW-1:0]     r_rcnt      [NUM_BTN];
    logic [RCW-1:0]     w_rcnt_nxt  [NUM_BTN];

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : gen_deb
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .CLK     (CLK),
            .RST     (RST),
            .i_key_n (bus.key_in[gi]),
            .o_level (w_deb[gi]),
            .o_raw   (w_raw[gi])
        );
    end

    // Gate on the value game_en takes this edge so press/repeat never coexist with game_en = 0.
    assign w_en_nxt = bus.mcu_str;
    assign w_merged = w_deb | bus.mcu_btn;
    assign w_rise   = w_merged & ~r_level & r_armed & {NUM_BTN{w_en_nxt}};
    assign w_fall   = ~w_merged & r_level;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            w_state_nxt[i] = r_state[i];
            w_rcnt_nxt[i]  = r_rcnt[i];
            w_fire[i]      = 1'b0;
            if (!w_merged[i] || !w_en_nxt) begin
                w_state_nxt[i] = IDLE;
                w_rcnt_nxt[i]  = '0;
            end else begin
                case (r_state[i])
                    IDLE: begin
                        if (w_rise[i]) begin
                            w_state_nxt[i] = DELAY;
                            w_rcnt_nxt[i]  = '0;
                        end
                    end
                    DELAY: begin
                        if (r_rcnt[i] >= DELAY_LAST) begin
                            w_fire[i]      = 1'b1;
                            w_state_nxt[i] = REPEAT;
                            w_rcnt_nxt[i]  = '0;
                        end else begin
                            w_rcnt_nxt[i] = r_rcnt[i] + RCW'(1);
                        end
                    end
                    REPEAT: begin
                        if (r_rcnt[i] >= RATE_LAST) begin
                            w_fire[i]     = 1'b1;
                            w_rcnt_nxt[i] = '0;
                        end else begin
                            w_rcnt_nxt[i] = r_rcnt[i] + RCW'(1);
                        end
                    end
                    default: begin
                        w_state_nxt[i] = IDLE;
                        w_rcnt_nxt[i]  = '0;
                    end
                endcase
            end
        end
    end

    // NOTE: the per-button state arrays are plain flops, not RAM, so they take the reset like any register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_state[i] <= IDLE;
                r_rcnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_rcnt[i]  <= w_rcnt_nxt[i];
            end
        end
    end

    // A button held through reset must be seen released (after the synchronizers settle) before it can press.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_level     <= '0;
            r_press     <= '0;
            r_release   <= '0;
            r_repeat    <= '0;
            r_armed     <= '0;
            r_settle    <= '0;
            r_sw        <= '0;
            r_sw_d      <= '0;
            r_sw_change <= 1'b0;
            r_game_en   <= 1'b0;
        end else begin
            r_level     <= w_merged;
            r_press     <= w_rise;
            r_release   <= w_fall;
            r_repeat    <= w_fire;
            r_settle    <= {r_settle[0], 1'b1};
            r_armed     <= r_armed | (~w_merged & ~w_raw & {NUM_BTN{r_settle[1]}});
            r_sw        <= bus.mcu_sw;
            r_sw_d      <= r_sw;
            r_sw_change <= |(r_sw ^ r_sw_d);
            r_game_en   <= bus.mcu_str;
        end
    end

    assign bus.btn_level   = r_level;
    assign bus.btn_press   = r_press;
    assign bus.btn_release = r_release;
    assign bus.btn_repeat  = r_repeat;
    assign bus.sw_level    = r_sw;
    assign bus.sw_change   = r_sw_change;
    assign bus.game_en     = r_game_en;

endmodule

// File: tb/tb_game_input_ctrl.sv
// Scoreboard bench: each stimulus step queues the outputs expected after the next edge; a monitor compares.
module tb_game_input_ctrl;

    typedef struct packed {
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
        logic [1:0] rpt;
        logic [1:0] swl;
        logic       swc;
        logic       gen;
    } obs_t;

    typedef struct {
        obs_t  o;
        string tag;
        int    k;
    } sb_t;

    localparam logic [1:0] Z = 2'b00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    sb_t  exp_q[$];

    game_input_if bus ();

    game_input_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (3)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] b0(input bit c);
        return {1'b0, c};
    endfunction

    function automatic logic [1:0] b1(input bit c);
        return {c, 1'b0};
    endfunction

    function automatic obs_t mk(input logic [1:0] lvl, prs, rel, rpt, swl, input logic swc, gen);
        obs_t o;
        o.lvl = lvl; o.prs = prs; o.rel = rel; o.rpt = rpt;
        o.swl = swl; o.swc = swc; o.gen = gen;
        return o;
    endfunction

    task automatic check(input string tag, input int k, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got lvl=%b prs=%b rel=%b rpt=%b swl=%b swc=%b gen=%b, want lvl=%b prs=%b rel=%b rpt=%b swl=%b swc=%b gen=%b",
                     tag, k, act.lvl, act.prs, act.rel, act.rpt, act.swl, act.swc, act.gen,
                     exp.lvl, exp.prs, exp.rel, exp.rpt, exp.swl, exp.swc, exp.gen);
        end
    endtask

    task automatic step(input string tag, input int k, input logic [1:0] key_n, btn, sw,
                        input logic str, rst_v, input obs_t e);
        sb_t s;
        bus.key_in  = key_n;
        bus.mcu_btn = btn;
        bus.mcu_sw  = sw;
        bus.mcu_str = str;
        rst         = rst_v;
        s.o   = e;
        s.tag = tag;
        s.k   = k;
        exp_q.push_back(s);
        @(negedge clk);
    endtask

    // Monitor: outputs are sampled 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                sb_t  s;
                obs_t a;
                s = exp_q.pop_front();
                a.lvl = bus.btn_level;
                a.prs = bus.btn_press;
                a.rel = bus.btn_release;
                a.rpt = bus.btn_repeat;
                a.swl = bus.sw_level;
                a.swc = bus.sw_change;
                a.gen = bus.game_en;
                check(s.tag, s.k, a, s.o);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.key_in  = 2'b11;
        bus.mcu_btn = 2'b00;
        bus.mcu_sw  = 2'b00;
        bus.mcu_str = 1'b0;
        @(negedge clk);

        // Reset with every input active: all outputs must stay 0.
        for (int k = 0; k < 4; k++)
            step("reset", k, 2'b00, 2'b11, 2'b11, 1'b1, 1'b1, mk(Z, Z, Z, Z, Z, 1'b0, 1'b0));

        for (int k = 0; k < 6; k++)
            step("idle", k, 2'b11, Z, Z, 1'b1, 1'b0, mk(Z, Z, Z, Z, Z, 1'b0, 1'b1));

        // Three-cycle glitch on key 0: one short of the debounce window.
        for (int k = 0; k < 12; k++)
            step("glitch", k, (k < 3) ? 2'b10 : 2'b11, Z, Z, 1'b1, 1'b0,
                 mk(Z, Z, Z, Z, Z, 1'b0, 1'b1));

        // Key 0 held 20 cycles: press at +6, repeats at +16/+19/+22/+25, release at +26.
        for (int k = 0; k < 30; k++)
            step("key_hold", k, (k < 20) ? 2'b10 : 2'b11, Z, Z, 1'b1, 1'b0,
                 mk((k >= 6 && k <= 25) ? 2'b01 : 2'b00, b0(k == 6), b0(k == 26),
                    b0(k == 16 || k == 19 || k == 22 || k == 25), Z, 1'b0, 1'b1));

        // One-cycle MCU button 1.
        for (int k = 0; k < 4; k++)
            step("mcu_tap", k, 2'b11, b1(k == 0), Z, 1'b1, 1'b0,
                 mk(b1(k == 0), b1(k == 0), b1(k == 1), Z, Z, 1'b0, 1'b1));

        // Release lands on a repeat expiry: release wins, no repeat at +13.
        for (int k = 0; k < 16; k++)
            step("rel_vs_rpt", k, 2'b11, b1(k < 13), Z, 1'b1, 1'b0,
                 mk(b1(k < 13), b1(k == 0), b1(k == 13), b1(k == 10), Z, 1'b0, 1'b1));

        // Game disabled while button 0 is pressed, then enabled mid-hold, then released while disabled.
        for (int k = 0; k < 31; k++) begin
            logic str_v;
            str_v = (k >= 13 && k <= 25) || k >= 28;
            step("game_en", k, 2'b11, b0(k >= 1 && k <= 26), Z, str_v, 1'b0,
                 mk(b0(k >= 1 && k <= 26), Z, b0(k == 27), Z, Z, 1'b0, str_v));
        end

        // Switches: level after 1 cycle, change pulse after 2, both directions.
        for (int k = 0; k < 10; k++) begin
            logic [1:0] sw_v;
            sw_v = (k < 6) ? 2'b01 : 2'b00;
            step("switch", k, 2'b11, Z, sw_v, 1'b1, 1'b0,
                 mk(Z, Z, Z, Z, sw_v, (k == 1 || k == 7), 1'b1));
        end

        // Reset while button 0 is in REPEAT; held through reset it must not press or repeat.
        for (int k = 0; k < 35; k++) begin
            logic       held;
            logic       in_rst;
            held   = (k <= 29) || k == 31;
            in_rst = (k == 14);
            if (in_rst)
                step("rst_repeat", k, 2'b11, 2'b01, Z, 1'b1, 1'b1, mk(Z, Z, Z, Z, Z, 1'b0, 1'b0));
            else
                step("rst_repeat", k, 2'b11, b0(held), Z, 1'b1, 1'b0,
                     mk(b0(held), b0(k == 0 || k == 31), b0(k == 30 || k == 32),
                        b0(k == 10 || k == 13), Z, 1'b0, 1'b1));
        end

        for (int k = 0; k < 2; k++)
            step("tail", k, 2'b11, Z, Z, 1'b1, 1'b0, mk(Z, Z, Z, Z, Z, 1'b0, 1'b1));

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_input_ctrl.md
GAME_INPUT_CTRL -- requirements
Module: game_input_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a physical key change.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 25000000: held cycles from press to first repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_RATE, default 5000000: cycles between subsequent repeat pulses.
REQ-004 The block SHALL have one clock and a synchronous active-high reset: CLK in 1, rising-edge clock for all state.
REQ-005 RST in 1: synchronous, active-high reset.
REQ-006 key_in in 2: physical push-buttons, asynchronous, active-low.
REQ-007 mcu_btn in 2: MCU virtual buttons from the AHB register slave, CLK domain, active-high.
REQ-008 mcu_sw in 2: MCU virtual switches, CLK domain.
REQ-009 mcu_str in 1: game enable from the MCU, CLK domain.
REQ-010 btn_level out 2: merged, debounced button state, 1 = pressed.
REQ-011 btn_press out 2: one-cycle pulse on each 0->1 of btn_level.
REQ-012 btn_release out 2: one-cycle pulse on each 1->0 of btn_level.
REQ-013 btn_repeat out 2: one-cycle auto-repeat pulses while a button is held.
REQ-014 sw_level out 2: registered copy of mcu_sw.
REQ-015 sw_change out 1: one-cycle pulse when any sw_level bit changes.
REQ-016 game_en out 1: registered copy of mcu_str.

Function
REQ-017 key_in SHALL pass through a 2-flop synchronizer and be inverted to active-high before debouncing.
REQ-018 Each debouncer SHALL count while the synchronized input differs from its accepted state, SHALL reset its count whenever they match, and SHALL update its accepted state when the count reaches DEBOUNCE_CYCLES; a glitch shorter than DEBOUNCE_CYCLES SHALL never change state.
REQ-019 merged[i] = debounced[i] OR mcu_btn[i]; btn_level SHALL register merged with 1-cycle latency.
REQ-020 btn_press/btn_release SHALL be registered and asserted in the same cycle btn_level changes.
REQ-021 Each button SHALL have a repeat FSM with states IDLE, DELAY, REPEAT: IDLE->DELAY on press with counter cleared; DELAY->REPEAT when counter = REPEAT_DELAY-1, emitting btn_repeat; in REPEAT, btn_repeat fires each time the counter reaches REPEAT_RATE-1 and the counter clears; any state->IDLE when btn_level = 0.
REQ-022 Release and a repeat expiry in the same cycle SHALL resolve to release: no btn_repeat.
REQ-023 When game_en = 0, btn_press and btn_repeat SHALL be forced 0 and repeat FSMs held in IDLE; btn_level, btn_release and sw outputs SHALL remain live.
REQ-024 When game_en rises while a button is held, no btn_press SHALL be generated for that hold; the FSM SHALL stay IDLE until the next press.
REQ-025 sw_change SHALL be asserted the cycle after sw_level differs from its previous value, i.e. 2 cycles after the mcu_sw change.
REQ-026 Counters SHALL be sized by $clog2 of their parameter and SHALL saturate, never wrap.

Reset
REQ-027 While RST = 1 at a CLK edge, all outputs SHALL be 0; synchronizers SHALL load 1, meaning released; debounced states, counters and FSMs SHALL clear to 0/IDLE.
REQ-028 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no pulse emitted; the first pulse after reset release SHALL require a fresh 0->1 of btn_level.

Structure
REQ-029 Package game_input_pkg SHALL hold the repeat-state enum (IDLE=0, DELAY=1, REPEAT=2) and the default parameter constants.
REQ-030 Sub-module key_debounce SHALL contain the synchronizer and debounce for one key, instantiated twice; edge detection, repeat FSM and switch logic SHALL stay in game_input_ctrl.

Verification (bench parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-031 key_in[0] low for 3 cycles then high -> btn_level stays 00, no pulses.
REQ-032 key_in[0] held low 20 cycles with game_en=1 -> btn_press[0] once, 2 sync + 4 debounce + 1 register cycles after the low edge; btn_repeat[0] 10 cycles after press, then every 3 cycles; btn_release[0] once after the return high plus the same latency.
REQ-033 mcu_btn=10 for 1 cycle -> btn_level=10 for 1 cycle, then btn_press[1] and btn_release[1] in consecutive cycles.
REQ-034 game_en=0, mcu_btn[0] held -> btn_level[0]=1, no press or repeat; game_en set to 1 while held -> still no press.
REQ-035 mcu_sw 00->01 -> sw_level=01 after 1 cycle, sw_change pulse after 2 cycles; mcu_sw held -> no further pulse.
REQ-036 RST asserted in REPEAT state -> all outputs 0 on the next cycle; after release with the button held, no btn_repeat and no btn_press occur until the button is released and pressed again.
